// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and sizing helpers for the sequential binary-to-BCD converter
package bin2bcd_pkg;

  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  localparam int BCD_DIGIT_W = 4;

  // ceil(w * log10(2)) with log10(2) approximated as 0.30103
  function automatic int min_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bcd_dabble_cell.sv
// rtl/bcd_dabble_cell.sv - one BCD digit of the shift-and-add-3 chain
module bcd_dabble_cell (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - double-dabble converter, one bit per clock; BIN2BCD_BLANK_EN adds blank_o
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W      = 18,
  parameter int ND     = 6,
  parameter int SIGNED = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              bin_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BCD_DIGIT_W*ND-1:0] bcd_o,
  output logic                      neg_o,
  output logic                      ovf_o,
  output logic                      busy_o
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [ND-1:0]             blank_o
`endif
);

  localparam int DW = BCD_DIGIT_W * ND;
  localparam int CW = cnt_width(W);

  if (ND < 1) begin : g_nd_chk
    $error("bin2bcd_seq: ND must be at least 1");
  end

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_mag;
  logic [DW-1:0]   r_dig;
  logic            r_neg_cap;
  logic            r_ovf_cap;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_bcd;
  logic            r_neg;
  logic            r_ovf;

  logic [DW-1:0]   w_adj;
  logic [DW-1:0]   w_dig_nxt;
  logic            w_carry;
  logic            w_last;
  logic            w_accept;
  logic            w_neg_in;
  logic [W-1:0]    w_mag_in;

  for (genvar g = 0; g < ND; g++) begin : g_cell
    bcd_dabble_cell u_cell (
      .digit_i (r_dig[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The bit leaving the top digit is lost from the window, so it marks overflow
  assign w_carry   = w_adj[DW-1];
  assign w_dig_nxt = {w_adj[DW-2:0], r_mag[W-1]};
  assign w_last    = (r_cnt == CW'(W - 1));
  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_neg_in  = (SIGNED != 0) && bin_i[W-1];
  assign w_mag_in  = w_neg_in ? W'(~bin_i + W'(1)) : bin_i;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = CONV;
      CONV:    if (w_last) w_next = HOLD;
      HOLD:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == HOLD);
    busy_o    = (r_state == CONV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag     <= '0;
      r_dig     <= '0;
      r_neg_cap <= 1'b0;
      r_ovf_cap <= 1'b0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_mag     <= w_mag_in;
      r_dig     <= '0;
      r_neg_cap <= w_neg_in;
      r_ovf_cap <= 1'b0;
      r_cnt     <= '0;
    end else if (r_state == CONV) begin
      r_mag     <= {r_mag[W-2:0], 1'b0};
      r_dig     <= w_dig_nxt;
      r_ovf_cap <= r_ovf_cap | w_carry;
      r_cnt     <= r_cnt + CW'(1);
      if (w_last) begin
        r_bcd <= w_dig_nxt;
        r_neg <= r_neg_cap;
        r_ovf <= r_ovf_cap | w_carry;
      end
    end
  end

  assign bcd_o = r_bcd;
  assign neg_o = r_neg;
  assign ovf_o = r_ovf;

`ifdef BIN2BCD_BLANK_EN
  logic [ND-1:0] w_blank_nxt;
  logic [ND-1:0] r_blank;

  // Bit 0 never blanks so a zero result still shows one digit
  always_comb begin
    logic v_zero;
    v_zero      = 1'b1;
    w_blank_nxt = '0;
    for (int i = ND - 1; i >= 1; i--) begin
      v_zero         = v_zero && (w_dig_nxt[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      w_blank_nxt[i] = v_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                  r_blank <= '0;
    else if ((r_state == CONV) && w_last)     r_blank <= w_blank_nxt;
  end

  assign blank_o = r_blank;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq (default and ND=4 unsigned instances)
module tb_bin2bcd_seq;

  localparam int W = 18;

  typedef struct {
    logic [39:0] bcd;
    bit          neg;
    bit          ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [17:0] bin_i = '0;
  logic        in_ready, out_valid, neg_o, ovf_o, busy_o;
  logic [23:0] bcd_o;

  logic        in_valid4 = 1'b0;
  logic        out_ready4 = 1'b0;
  logic [17:0] bin_i4 = '0;
  logic        in_ready4, out_valid4, neg_o4, ovf_o4, busy_o4;
  logic [15:0] bcd_o4;

`ifdef BIN2BCD_BLANK_EN
  logic [5:0]  blank_o;
  logic [3:0]  blank_o4;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t sb4[$];

  always #5 clk = ~clk;

  bin2bcd_seq #(.W(18), .ND(6), .SIGNED(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_i     (bin_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_o     (bcd_o),
    .neg_o     (neg_o),
    .ovf_o     (ovf_o),
    .busy_o    (busy_o)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank_o   (blank_o)
`endif
  );

  bin2bcd_seq #(.W(18), .ND(4), .SIGNED(0)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .bin_i     (bin_i4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .bcd_o     (bcd_o4),
    .neg_o     (neg_o4),
    .ovf_o     (ovf_o4),
    .busy_o    (busy_o4)
`ifdef BIN2BCD_BLANK_EN
    ,
    .blank_o   (blank_o4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [17:0] b, input int nd, input bit sgn);
    exp_t   e;
    longint mag;
    longint lim;
    e.bcd = '0;
    e.neg = sgn && b[17];
    mag   = e.neg ? (longint'(262144) - longint'(b)) : longint'(b);
    lim   = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    e.ovf = (mag >= lim);
    for (int i = 0; i < nd; i++) begin
      e.bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return e;
  endfunction

  function automatic logic [5:0] blank_model(input logic [39:0] d);
    logic [5:0] r;
    bit         z;
    r = '0;
    z = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      z    = z && (d[4*i +: 4] == 4'd0);
      r[i] = z;
    end
    return r;
  endfunction

  task automatic run_main(input logic [17:0] val, input bit chk_lat, input bit release_now);
    exp_t e;
    int   lat;
    int   busy_cnt;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL main_in_ready_before_accept: got %b expected 1", in_ready);
    end
    bin_i    = val;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb.push_back(model(val, 6, 1'b1));
    lat      = 0;
    busy_cnt = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (busy_o === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL main_timeout: out_valid never rose for %0d", val);
      void'(sb.pop_front());
      return;
    end
    if (chk_lat) begin
      n_vec++;
      if (lat !== W) begin
        n_err++;
        $display("FAIL main_latency: got %0d expected %0d", lat, W);
      end
      n_vec++;
      if (busy_cnt !== W) begin
        n_err++;
        $display("FAIL main_busy_cycles: got %0d expected %0d", busy_cnt, W);
      end
    end
    e = sb.pop_front();
    n_vec++;
    if (bcd_o !== e.bcd[23:0]) begin
      n_err++;
      $display("FAIL main_bcd(%0d): got %h expected %h", val, bcd_o, e.bcd[23:0]);
    end
    n_vec++;
    if (neg_o !== e.neg || ovf_o !== e.ovf) begin
      n_err++;
      $display("FAIL main_flags(%0d): got neg=%b ovf=%b expected neg=%b ovf=%b",
               val, neg_o, ovf_o, e.neg, e.ovf);
    end
`ifdef BIN2BCD_BLANK_EN
    n_vec++;
    if (blank_o !== blank_model(e.bcd)) begin
      n_err++;
      $display("FAIL main_blank(%0d): got %b expected %b", val, blank_o, blank_model(e.bcd));
    end
`endif
    if (release_now) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL main_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
      end
    end
  endtask

  task automatic run_nd4(input logic [17:0] val);
    exp_t e;
    int   lat;
    bin_i4    = val;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    sb4.push_back(model(val, 4, 1'b0));
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    n_vec++;
    if (out_valid4 !== 1'b1) begin
      n_err++;
      $display("FAIL nd4_timeout: out_valid never rose for %0d", val);
      void'(sb4.pop_front());
      return;
    end
    e = sb4.pop_front();
    n_vec++;
    if (bcd_o4 !== e.bcd[15:0] || ovf_o4 !== e.ovf || neg_o4 !== 1'b0) begin
      n_err++;
      $display("FAIL nd4_result(%0d): got bcd=%h ovf=%b neg=%b expected bcd=%h ovf=%b neg=0",
               val, bcd_o4, ovf_o4, neg_o4, e.bcd[15:0], e.ovf);
    end
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    n_vec++;
    if (bcd_o !== '0 || neg_o !== 1'b0 || ovf_o !== 1'b0 || out_valid !== 1'b0 ||
        busy_o !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s: got bcd=%h neg=%b ovf=%b ov=%b busy=%b ir=%b expected 0 0 0 0 0 1",
               tag, bcd_o, neg_o, ovf_o, out_valid, busy_o, in_ready);
    end
`ifdef BIN2BCD_BLANK_EN
    n_vec++;
    if (blank_o !== '0) begin
      n_err++;
      $display("FAIL %s_blank: got %b expected 0", tag, blank_o);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_idle_zero("reset_main");
    n_vec++;
    if (bcd_o4 !== '0 || out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy_o4 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_nd4: got bcd=%h ov=%b ir=%b busy=%b expected 0 0 1 0",
               bcd_o4, out_valid4, in_ready4, busy_o4);
    end
  endtask

  task automatic test_basic();
    run_main(18'd12345, 1'b1, 1'b1);
    run_main(18'd0, 1'b1, 1'b1);
    run_main(18'd131071, 1'b0, 1'b1);
  endtask

  task automatic test_signed();
    run_main(18'h20000, 1'b0, 1'b1);
    run_main(18'h3FFFF, 1'b0, 1'b1);
    run_main(18'h3CFC7, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    exp_t e;
    e = model(18'd54321, 6, 1'b1);
    run_main(18'd54321, 1'b0, 1'b0);
    bin_i    = 18'd777;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (bcd_o !== e.bcd[23:0] || out_valid !== 1'b1 || in_ready !== 1'b0 || busy_o !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d: got bcd=%h ov=%b ir=%b busy=%b expected %h 1 0 0",
                 i, bcd_o, out_valid, in_ready, busy_o, e.bcd[23:0]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release: got ir=%b ov=%b expected 1 0", in_ready, out_valid);
    end
    run_main(18'd777, 1'b1, 1'b1);
  endtask

  task automatic test_overflow();
    run_nd4(18'd99999);
    run_nd4(18'd9999);
    run_nd4(18'd10000);
    run_nd4(18'd262143);
  endtask

  task automatic test_reset_mid_conv();
    run_main(18'd999, 1'b0, 1'b1);
    bin_i    = 18'd98765;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb.push_back(model(18'd98765, 6, 1'b1));
    repeat (4) tick();
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL midconv_busy: got %b expected 1", busy_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check_idle_zero("midconv_reset");
    run_main(18'd42, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [17:0] v;
    for (int i = 0; i < 6; i++) begin
      v = 18'($urandom_range(0, 262143));
      run_main(v, 1'b1, 1'b1);
      v = 18'($urandom_range(0, 262143));
      run_nd4(v);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_overflow();
    test_reset_mid_conv();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
